// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed byte stream, writes the
// payload into program RAM starting at address 0, and releases the CPU from
// clear only once the checksum matches.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    // Largest legal length: the whole RAM.
    localparam int unsigned CAP = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;       // next payload write address
    logic [ADDR_W-1:0] len_m1_q, len_m1_d;   // N-1, so N = 2^ADDR_W fits in ADDR_W bits
    logic [DATA_W-1:0] sum_q, sum_d;         // running payload checksum
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              len_legal;

    // Length byte is legal when 1 <= N <= capacity.
    assign len_legal = (in_data != '0) && (32'(in_data) <= CAP);

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        len_m1_d   = len_m1_q;
        sum_d      = sum_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_clr  = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end

            S_LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                addr_d   = '0;
                sum_d    = '0;
                if (in_valid) begin
                    if (len_legal) begin
                        len_m1_d = ADDR_W'(in_data - DATA_W'(1));
                        state_d  = S_DATA;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_data_d = in_data;
                    sum_d      = sum_q + in_data;
                    // The last byte leaves the counter in place so it never wraps.
                    if (addr_q == len_m1_q) state_d = S_CSUM;
                    else                    addr_d  = addr_q + ADDR_W'(1);
                end
            end

            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_d = (in_data == sum_q) ? S_RUN : S_ERR;
            end

            S_RUN: begin
                done    = 1'b1;
                cpu_clr = 1'b0;
                if (start) state_d = S_LEN;
            end

            S_ERR: begin
                err = 1'b1;
                if (start) state_d = S_LEN;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; clr drops any pending write.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_m1_q   <= '0;
            sum_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_m1_q   <= len_m1_d;
            sum_q      <= sum_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: a behavioural RAM captures writes and
// each scenario task checks outputs #1 after the rising edge.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_clr;
    logic       busy;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] tb_mem [16];
    int         wr_count = 0;

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .cpu_clr  (cpu_clr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Program RAM model.
    always @(posedge clk) begin
        if (ram_we) begin
            tb_mem[ram_addr] <= ram_data;
            wr_count         <= wr_count + 1;
        end
    end

    // One accepted (or offered) byte: valid for exactly one rising edge.
    task automatic xfer(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Compare the five status outputs against {in_ready,busy,done,err,cpu_clr}.
    task automatic chk_status(input string name, input logic [4:0] exp);
        n_vec++;
        if ({in_ready, busy, done, err, cpu_clr} !== exp) begin
            n_err++;
            $display("FAIL %s: {rdy,busy,done,err,cpu_clr} got %b want %b", name,
                     {in_ready, busy, done, err, cpu_clr}, exp);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        chk_status("reset_status", 5'b00001);
        n_vec++;
        if ({ram_we, ram_addr, ram_data} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_ram_if: got we=%b a=%h d=%h want 0/0/0", ram_we, ram_addr, ram_data);
        end
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk_status("idle_after_reset", 5'b00001);
    endtask

    task automatic test_full_load();
        logic [7:0] prog [16];
        int w0;
        prog = '{8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h38, 8'h23};
        w0 = wr_count;
        pulse_start();
        chk_status("full_len_state", 5'b11001);
        xfer(8'h10);
        for (int i = 0; i < 16; i++) xfer(prog[i]);
        // Last write still in flight while the loader waits for the checksum.
        chk_status("full_csum_state", 5'b11001);
        n_vec++;
        if ({ram_we, ram_addr, ram_data} !== {1'b1, 4'hF, 8'h23}) begin
            n_err++;
            $display("FAIL full_last_write: got we=%b a=%h d=%h want 1/f/23", ram_we, ram_addr, ram_data);
        end
        xfer(8'h78);
        chk_status("full_run", 5'b00100);
        n_vec++;
        if (tb_mem[0] !== 8'h1E || tb_mem[15] !== 8'h23 || tb_mem[2] !== 8'hE0) begin
            n_err++;
            $display("FAIL full_ram: got m0=%h m2=%h mF=%h want 1e/e0/23", tb_mem[0], tb_mem[2], tb_mem[15]);
        end
        n_vec++;
        if (wr_count - w0 !== 16) begin
            n_err++;
            $display("FAIL full_wr_count: got %0d want 16", wr_count - w0);
        end
    endtask

    task automatic test_bad_csum();
        pulse_start();
        xfer(8'h02);
        // start held during a DATA transfer must be ignored.
        start = 1'b1;
        xfer(8'h11);
        start = 1'b0;
        chk_status("start_ignored_in_data", 5'b11001);
        xfer(8'h22);
        xfer(8'h34);
        chk_status("bad_csum_err", 5'b00011);
        n_vec++;
        if (tb_mem[0] !== 8'h11 || tb_mem[1] !== 8'h22) begin
            n_err++;
            $display("FAIL bad_csum_ram: got m0=%h m1=%h want 11/22", tb_mem[0], tb_mem[1]);
        end
    endtask

    task automatic test_bad_len();
        int w0;
        w0 = wr_count;
        pulse_start();
        xfer(8'h00);
        chk_status("len_zero_err", 5'b00011);
        n_vec++;
        if (ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL len_zero_we: got %b want 0", ram_we);
        end
        pulse_start();
        xfer(8'h11);
        chk_status("len_17_err", 5'b00011);
        @(posedge clk);
        #1;
        n_vec++;
        if (wr_count !== w0) begin
            n_err++;
            $display("FAIL bad_len_writes: got %0d want 0", wr_count - w0);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] gb [4];
        gb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start();
        @(posedge clk);
        #1;
        xfer(8'h04);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            xfer(gb[i]);
            n_vec++;
            if ({ram_we, ram_addr, ram_data} !== {1'b1, 4'(i), gb[i]}) begin
                n_err++;
                $display("FAIL gap_write_%0d: got we=%b a=%h d=%h want 1/%h/%h", i,
                         ram_we, ram_addr, ram_data, 4'(i), gb[i]);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (ram_we !== 1'b0) begin
                n_err++;
                $display("FAIL gap_idle_%0d: ram_we got %b want 0", i, ram_we);
            end
        end
        xfer(8'h0E);
        chk_status("gap_run", 5'b00100);
        n_vec++;
        if (tb_mem[3] !== 8'hDD) begin
            n_err++;
            $display("FAIL gap_ram: got m3=%h want dd", tb_mem[3]);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        xfer(8'h04);
        xfer(8'h01);
        xfer(8'h02);
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        chk_status("mid_reset_status", 5'b00001);
        n_vec++;
        if ({ram_we, ram_addr, ram_data} !== 13'h0) begin
            n_err++;
            $display("FAIL mid_reset_ram_if: got we=%b a=%h d=%h want 0/0/0", ram_we, ram_addr, ram_data);
        end
        @(negedge clk);
        clr = 1'b0;
        n_vec++;
        if (tb_mem[0] !== 8'h01 || tb_mem[1] !== 8'h02) begin
            n_err++;
            $display("FAIL mid_reset_retained: got m0=%h m1=%h want 01/02", tb_mem[0], tb_mem[1]);
        end
        pulse_start();
        xfer(8'h01);
        xfer(8'h5A);
        xfer(8'h5A);
        chk_status("reload_run", 5'b00100);
        n_vec++;
        if (tb_mem[0] !== 8'h5A || tb_mem[1] !== 8'h02) begin
            n_err++;
            $display("FAIL reload_ram: got m0=%h m1=%h want 5a/02", tb_mem[0], tb_mem[1]);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        chk_status("restart_len", 5'b11001);
        xfer(8'h02);
        xfer(8'h33);
        xfer(8'h44);
        xfer(8'h77);
        chk_status("restart_run", 5'b00100);
        n_vec++;
        if (tb_mem[0] !== 8'h33 || tb_mem[1] !== 8'h44) begin
            n_err++;
            $display("FAIL restart_ram: got m0=%h m1=%h want 33/44", tb_mem[0], tb_mem[1]);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bad_csum();
        test_bad_len();
        test_gaps();
        test_reset_mid();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width; capacity is 2^ADDR_W bytes.
REQ-002 SHALL have parameter DATA_W, default 8, RAM word and stream byte width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins a load session when sampled high in IDLE, RUN or ERR.
REQ-006 SHALL have port in_data, input, DATA_W, stream byte.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid.
REQ-008 SHALL have port in_ready, output, 1, loader accepts a byte; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-009 SHALL have port ram_addr, output, ADDR_W, RAM write address.
REQ-010 SHALL have port ram_data, output, DATA_W, RAM write data.
REQ-011 SHALL have port ram_we, output, 1, RAM write strobe; one write per cycle high.
REQ-012 SHALL have port cpu_clr, output, 1, holds the computer in clear while high.
REQ-013 SHALL have port busy, output, 1, high in LEN, DATA and CSUM.
REQ-014 SHALL have port done, output, 1, high in RUN.
REQ-015 SHALL have port err, output, 1, high in ERR.

Function
REQ-016 SHALL implement the states IDLE, LEN, DATA, CSUM, RUN and ERR.
REQ-017 SHALL move IDLE->LEN on start=1; in LEN it SHALL clear the address counter and the checksum accumulator.
REQ-018 SHALL treat the LEN transfer as length N, legal range 1..2^ADDR_W (byte value 0 or >2^ADDR_W -> ERR); on a legal N it SHALL latch N and go to DATA.
REQ-019 SHALL, in DATA, accept exactly N bytes and write them to addresses 0..N-1 in order.
REQ-020 SHALL, in DATA, add each accepted byte to the accumulator modulo 2^DATA_W.
REQ-021 SHALL go DATA->CSUM after the Nth byte; the address counter SHALL NOT wrap within a session.
REQ-022 SHALL treat the CSUM transfer as the expected sum: equal -> RUN, unequal -> ERR; the checksum byte is not written to RAM.
REQ-023 SHALL assert in_ready=1 in LEN, DATA and CSUM, and 0 otherwise; it SHALL NOT stall the stream.
REQ-024 SHALL register writes: for a DATA transfer at edge k, ram_we=1 with the latched ram_addr/ram_data for exactly the cycle after edge k.
REQ-025 SHALL hold ram_we=0 at all other times; ram_addr/ram_data SHALL hold their last values when ram_we=0.
REQ-026 SHALL ignore cycles with in_valid=0; gaps of any length SHALL be tolerated.
REQ-027 SHALL drive cpu_clr=1 in every state except RUN and cpu_clr=0 in RUN, so the CPU starts from address 0 on the cycle after the CSUM match.
REQ-028 SHALL restart a session on start=1 in RUN or ERR (->LEN, cpu_clr reasserted next cycle); start SHALL be ignored in LEN, DATA and CSUM.
REQ-029 SHALL let a transfer on the same edge as start in IDLE/RUN/ERR be ignored (in_ready=0 there).
REQ-030 SHALL let the final DATA write (ram_we) complete in the cycle the loader is in CSUM.

Reset
REQ-031 SHALL, on clr=1 at any time (including mid-session), enter IDLE immediately: in_ready=0, ram_we=0, ram_addr=0, ram_data=0, cpu_clr=1, busy=0, done=0, err=0, with counters and accumulator cleared.
REQ-032 SHALL NOT erase RAM contents already written; any pending write is dropped.

Verification
REQ-033 SHALL be verified on the full load: start, then 10, then 1E 2F E0 F0, ten times 00, then 38 23, then 78 -> 16 writes with addr0=1E and addrF=23, done=1, cpu_clr=0; the CPU then outputs 5B.
REQ-034 SHALL be verified on a bad checksum: start, 02, 11, 22, 34 (expected 33) -> addr0=11, addr1=22, err=1, cpu_clr=1, done=0.
REQ-035 SHALL be verified on illegal lengths: start then 00 -> err=1 with no ram_we; start then 11 -> err=1.
REQ-036 SHALL be verified with gaps: in_valid toggling 1/0 during a 04 / AA BB CC DD / 0E session -> writes occur one cycle after each accept, done=1.
REQ-037 SHALL be verified on reset mid-session: clr pulsed after the 2nd DATA byte of a 4-byte load -> all outputs at reset values within the cycle, RAM addr0/addr1 retained; a new start reloads correctly.
REQ-038 SHALL be verified on restart from RUN: start in RUN -> cpu_clr=1 next cycle, busy=1, and a second program loads.
